// File: rtl/alu_decode_stage_if.sv
// Handshake and decoded-control bundle between fetch, the ALU decode stage and execute.
// The slave modport is the decode stage; the master modport is the fetch/execute side.
interface alu_decode_stage_if #(
  parameter int ENABLE_W = 41
);
  logic                in_valid;
  logic                in_ready;
  logic [15:0]         instr;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [ENABLE_W-1:0] enable;
  logic                use_carry;
  logic                b_is_const;
  logic [15:0]         b_const;
  logic                byte_op;
  logic [2:0]          src;
  logic [2:0]          dst;
  logic                write_en;
  logic                illegal;
  logic [15:0]         decode_count;

  modport slave (
    input  in_valid, instr, flush, out_ready,
    output in_ready, out_valid, enable, use_carry, b_is_const, b_const,
           byte_op, src, dst, write_en, illegal, decode_count
  );

  modport master (
    output in_valid, instr, flush, out_ready,
    input  in_ready, out_valid, enable, use_carry, b_is_const, b_const,
           byte_op, src, dst, write_en, illegal, decode_count
  );
endinterface

// File: rtl/alu_decode_stage.sv
// Registered XM23 ALU-group decode stage: single-entry valid/ready pipeline register
// with flush, producing the one-hot ALU enable vector and operand/write-back controls.
module alu_decode_stage #(
  parameter int ENABLE_W = 41,
  parameter int ALU_BASE = 9
) (
  input logic               clk,
  input logic               rst_n,
  alu_decode_stage_if.slave bus
);

  localparam logic [ENABLE_W-1:0] ONE_HOT_LSB = {{(ENABLE_W-1){1'b0}}, 1'b1};

  function automatic logic [15:0] const_lookup(input logic [2:0] sss);
    logic [15:0] v;
    case (sss)
      3'd0:    v = 16'h0000;
      3'd1:    v = 16'h0001;
      3'd2:    v = 16'h0002;
      3'd3:    v = 16'h0004;
      3'd4:    v = 16'h0008;
      3'd5:    v = 16'h0010;
      3'd6:    v = 16'h0020;
      3'd7:    v = 16'hFFFF;
      default: v = 16'h0000;
    endcase
    return v;
  endfunction

  logic [3:0]          w_op;
  logic                w_is_alu;
  logic [ENABLE_W-1:0] w_enable;
  logic                w_use_carry;
  logic                w_b_is_const;
  logic [15:0]         w_b_const;
  logic                w_write_en;
  logic                w_illegal;
  logic                w_in_ready;
  logic                w_accept;
  logic                w_consume;

  logic                r_out_valid;
  logic [ENABLE_W-1:0] r_enable;
  logic                r_use_carry;
  logic                r_b_is_const;
  logic [15:0]         r_b_const;
  logic                r_byte_op;
  logic [2:0]          r_src;
  logic [2:0]          r_dst;
  logic                r_write_en;
  logic                r_illegal;
  logic [15:0]         r_decode_count;

  assign w_op     = bus.instr[11:8];
  assign w_is_alu = (bus.instr[15:12] == 4'b0100) && (w_op <= 4'hB);

  // Combinational decode of the presented instruction word.
  always_comb begin
    w_enable     = '0;
    w_use_carry  = 1'b0;
    w_b_is_const = 1'b0;
    w_b_const    = 16'h0000;
    w_write_en   = 1'b0;
    w_illegal    = 1'b1;
    if (w_is_alu) begin
      w_enable     = ONE_HOT_LSB << (ALU_BASE + int'(w_op));
      w_b_is_const = bus.instr[7];
      w_illegal    = 1'b0;
      case (w_op)
        4'h1, 4'h3, 4'h4: w_use_carry = 1'b1;
        default:          w_use_carry = 1'b0;
      endcase
      // CMP and BIT only update flags.
      case (w_op)
        4'h5, 4'h9: w_write_en = 1'b0;
        default:    w_write_en = 1'b1;
      endcase
      if (bus.instr[7]) begin
        w_b_const = const_lookup(bus.instr[5:3]);
      end else begin
        w_b_const = 16'h0000;
      end
    end else begin
      w_illegal = 1'b1;
    end
  end

  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready && !bus.flush;
  assign w_consume  = r_out_valid && bus.out_ready;

  // Pipeline register: flush beats accept and consume; fields hold when not loading.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid    <= 1'b0;
      r_enable       <= '0;
      r_use_carry    <= 1'b0;
      r_b_is_const   <= 1'b0;
      r_b_const      <= 16'h0000;
      r_byte_op      <= 1'b0;
      r_src          <= 3'd0;
      r_dst          <= 3'd0;
      r_write_en     <= 1'b0;
      r_illegal      <= 1'b0;
      r_decode_count <= 16'h0000;
    end else if (bus.flush) begin
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_out_valid  <= 1'b1;
        r_enable     <= w_enable;
        r_use_carry  <= w_use_carry;
        r_b_is_const <= w_b_is_const;
        r_b_const    <= w_b_const;
        r_byte_op    <= bus.instr[6];
        r_src        <= bus.instr[5:3];
        r_dst        <= bus.instr[2:0];
        r_write_en   <= w_write_en;
        r_illegal    <= w_illegal;
      end else if (w_consume) begin
        r_out_valid <= 1'b0;
      end else begin
        r_out_valid <= r_out_valid;
      end
      if (w_consume) begin
        r_decode_count <= r_decode_count + 16'd1;
      end else begin
        r_decode_count <= r_decode_count;
      end
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = r_out_valid;
  assign bus.enable       = r_enable;
  assign bus.use_carry    = r_use_carry;
  assign bus.b_is_const   = r_b_is_const;
  assign bus.b_const      = r_b_const;
  assign bus.byte_op      = r_byte_op;
  assign bus.src          = r_src;
  assign bus.dst          = r_dst;
  assign bus.write_en     = r_write_en;
  assign bus.illegal      = r_illegal;
  assign bus.decode_count = r_decode_count;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: a reference decoder pushes expected entries
// into a scoreboard queue at acceptance; each scenario task compares DUT outputs inline.
module tb_alu_decode_stage;

  typedef struct packed {
    logic [40:0] enable;
    logic        use_carry;
    logic        b_is_const;
    logic [15:0] b_const;
    logic        byte_op;
    logic [2:0]  src;
    logic [2:0]  dst;
    logic        write_en;
    logic        illegal;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  alu_decode_stage_if #(.ENABLE_W(41)) bus ();

  alu_decode_stage #(.ENABLE_W(41), .ALU_BASE(9)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int          n_pass  = 0;
  int          n_total = 0;
  exp_t        sb[$];
  logic [15:0] m_count = 16'h0000;

  int unsigned en_bit [12] = '{9, 10, 11, 12, 13, 14, 15, 16, 17, 18, 19, 20};
  logic [15:0] ctab   [8]  = '{16'h0000, 16'h0001, 16'h0002, 16'h0004,
                               16'h0008, 16'h0010, 16'h0020, 16'hFFFF};

  function automatic exp_t model(input logic [15:0] ins);
    exp_t e;
    int   op;
    e         = '0;
    op        = int'(ins[11:8]);
    e.src     = ins[5:3];
    e.dst     = ins[2:0];
    e.byte_op = ins[6];
    if (ins[15:12] == 4'h4 && op < 12) begin
      e.enable[en_bit[op]] = 1'b1;
      e.use_carry  = (op == 1) || (op == 3) || (op == 4);
      e.b_is_const = ins[7];
      e.b_const    = ins[7] ? ctab[ins[5:3]] : 16'h0000;
      e.write_en   = !((op == 5) || (op == 9));
      e.illegal    = 1'b0;
    end else begin
      e.illegal = 1'b1;
    end
    return e;
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o.enable     = bus.enable;
    o.use_carry  = bus.use_carry;
    o.b_is_const = bus.b_is_const;
    o.b_const    = bus.b_const;
    o.byte_op    = bus.byte_op;
    o.src        = bus.src;
    o.dst        = bus.dst;
    o.write_en   = bus.write_en;
    o.illegal    = bus.illegal;
    return o;
  endfunction

  // One clock: the scoreboard decides accept/consume from its own state, then advances.
  task automatic cycle();
    bit          acc;
    bit          cons;
    bit          fl;
    logic [15:0] ins;
    acc  = rst_n && bus.in_valid && (sb.size() == 0 || bus.out_ready) && !bus.flush;
    cons = rst_n && (sb.size() != 0) && bus.out_ready && !bus.flush;
    fl   = bus.flush;
    ins  = bus.instr;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      sb.delete();
      m_count = 16'h0000;
    end else if (fl) begin
      sb.delete();
    end else begin
      if (cons) begin
        void'(sb.pop_front());
        m_count = m_count + 16'd1;
      end
      if (acc) sb.push_back(model(ins));
    end
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.instr     = 16'h0000;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.instr     = 16'h4011;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) cycle();
    n_total++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %b exp 0", bus.out_valid);
    else n_pass++;
    n_total++;
    if (observe() !== exp_t'(0)) $display("FAIL reset_fields: got %h exp 0", observe());
    else n_pass++;
    n_total++;
    if (bus.decode_count !== 16'h0000) $display("FAIL reset_count: got %h exp 0000", bus.decode_count);
    else n_pass++;
    idle_inputs();
    rst_n = 1'b1;
    #1;
    n_total++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b exp 1", bus.in_ready);
    else n_pass++;
  endtask

  task automatic test_add();
    bus.in_valid  = 1'b1;
    bus.instr     = 16'h4011;
    bus.out_ready = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    n_total++;
    if (bus.out_valid !== 1'b1) $display("FAIL add_valid: got %b exp 1", bus.out_valid);
    else n_pass++;
    n_total++;
    if (bus.enable !== (41'd1 << 9) || bus.src !== 3'd2 || bus.dst !== 3'd1 ||
        bus.write_en !== 1'b1 || bus.use_carry !== 1'b0 || bus.b_is_const !== 1'b0)
      $display("FAIL add_fields: got en=%h src=%0d dst=%0d we=%b uc=%b rc=%b",
               bus.enable, bus.src, bus.dst, bus.write_en, bus.use_carry, bus.b_is_const);
    else n_pass++;
    n_total++;
    if (observe() !== sb[0]) $display("FAIL add_model: got %h exp %h", observe(), sb[0]);
    else n_pass++;
    cycle();
    n_total++;
    if (bus.out_valid !== 1'b0 || bus.decode_count !== 16'd1)
      $display("FAIL add_consume: got valid=%b count=%h exp valid=0 count=0001",
               bus.out_valid, bus.decode_count);
    else n_pass++;
  endtask

  task automatic test_const();
    logic [15:0] words [2] = '{16'h4188, 16'h41B8};
    logic [15:0] consts[2] = '{16'h0001, 16'hFFFF};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.instr    = words[i];
      cycle();
      n_total++;
      if (bus.enable !== (41'd1 << 10) || bus.b_is_const !== 1'b1 ||
          bus.b_const !== consts[i] || bus.use_carry !== 1'b1)
        $display("FAIL const_%0d: got en=%h rc=%b k=%h uc=%b exp k=%h",
                 i, bus.enable, bus.b_is_const, bus.b_const, bus.use_carry, consts[i]);
      else n_pass++;
      n_total++;
      if (bus.decode_count !== m_count) $display("FAIL const_count_%0d: got %h exp %h", i, bus.decode_count, m_count);
      else n_pass++;
    end
    bus.in_valid = 1'b0;
    cycle();
  endtask

  task automatic test_sweep();
    logic [15:0] words[9] = '{16'h4500, 16'h4900, 16'h4B00, 16'h4C00, 16'h6000,
                              16'h43D5, 16'h4F7F, 16'h4AFF, 16'h0000};
    bus.out_ready = 1'b1;
    foreach (words[i]) begin
      bus.in_valid = 1'b1;
      bus.instr    = words[i];
      cycle();
      n_total++;
      if (bus.out_valid !== 1'b1) $display("FAIL sweep_valid_%h: got %b exp 1", words[i], bus.out_valid);
      else n_pass++;
      n_total++;
      if (observe() !== sb[0]) $display("FAIL sweep_%h: got %h exp %h", words[i], observe(), sb[0]);
      else n_pass++;
    end
    bus.in_valid = 1'b0;
    cycle();
    n_total++;
    if (bus.decode_count !== m_count) $display("FAIL sweep_count: got %h exp %h", bus.decode_count, m_count);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    exp_t held;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.instr     = 16'h4200;
    cycle();
    held      = model(16'h4200);
    bus.instr = 16'h4300;
    #1;
    n_total++;
    if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b exp 0", bus.in_ready);
    else n_pass++;
    repeat (2) cycle();
    n_total++;
    if (bus.out_valid !== 1'b1 || observe() !== held)
      $display("FAIL bp_stable: got valid=%b %h exp valid=1 %h", bus.out_valid, observe(), held);
    else n_pass++;
    bus.out_ready = 1'b1;
    #1;
    n_total++;
    if (bus.in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b exp 1", bus.in_ready);
    else n_pass++;
    cycle();
    n_total++;
    if (bus.out_valid !== 1'b1 || observe() !== model(16'h4300) || bus.decode_count !== m_count)
      $display("FAIL b2b_first: got valid=%b %h cnt=%h exp %h cnt=%h",
               bus.out_valid, observe(), bus.decode_count, model(16'h4300), m_count);
    else n_pass++;
    bus.instr = 16'h4400;
    cycle();
    n_total++;
    if (bus.out_valid !== 1'b1 || observe() !== sb[0] || bus.decode_count !== m_count)
      $display("FAIL b2b_second: got valid=%b %h cnt=%h exp %h cnt=%h",
               bus.out_valid, observe(), bus.decode_count, sb[0], m_count);
    else n_pass++;
  endtask

  task automatic test_flush();
    logic [15:0] cnt_before;
    cnt_before = m_count;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    bus.instr     = 16'h4700;
    cycle();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    n_total++;
    if (bus.out_valid !== 1'b0) $display("FAIL flush_valid: got %b exp 0", bus.out_valid);
    else n_pass++;
    n_total++;
    if (bus.decode_count !== cnt_before) $display("FAIL flush_count: got %h exp %h", bus.decode_count, cnt_before);
    else n_pass++;
    cycle();
    n_total++;
    if (bus.out_valid !== 1'b0) $display("FAIL flush_no_accept: got %b exp 0", bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    bus.instr     = 16'h4812;
    cycle();
    rst_n = 1'b0;
    #1;
    sb.delete();
    m_count = 16'h0000;
    n_total++;
    if (bus.out_valid !== 1'b0 || bus.decode_count !== 16'h0000 || observe() !== exp_t'(0))
      $display("FAIL reset_mid: got valid=%b cnt=%h %h exp all 0", bus.out_valid, bus.decode_count, observe());
    else n_pass++;
    idle_inputs();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 3) != 0);
      bus.out_ready = 1'($urandom_range(0, 2) != 0);
      bus.flush     = 1'($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 4) == 0) bus.instr = 16'($urandom);
      else bus.instr = {4'h4, 12'($urandom)};
      cycle();
      n_total++;
      if (bus.out_valid !== (sb.size() != 0) || bus.decode_count !== m_count)
        $display("FAIL rand_%0d_ctrl: got valid=%b cnt=%h exp valid=%b cnt=%h",
                 i, bus.out_valid, bus.decode_count, sb.size() != 0, m_count);
      else n_pass++;
      if (sb.size() != 0) begin
        n_total++;
        if (observe() !== sb[0]) $display("FAIL rand_%0d_fields: got %h exp %h", i, observe(), sb[0]);
        else n_pass++;
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_add();
    test_const();
    test_sweep();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
